// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the 8-line interrupt controller: register map,
// command/vector bit positions and a line-index helper.
package irq_ctrl_pkg;

  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned IDX_W     = $clog2(NUM_LINES);

  localparam logic [7:0] OFS_PEND = 8'd0;
  localparam logic [7:0] OFS_MASK = 8'd1;
  localparam logic [7:0] OFS_CTRL = 8'd2;
  localparam logic [7:0] OFS_CMD  = 8'd3;
  localparam logic [7:0] OFS_ISR  = 8'd4;
  localparam logic [7:0] OFS_TRIG = 8'd5;
  localparam logic [7:0] NUM_REGS = 8'd6;

  localparam int unsigned CTRL_GEN    = 0;
  localparam int unsigned CMD_ACK     = 0;
  localparam int unsigned CMD_EOI     = 1;
  localparam int unsigned VEC_IDX_LSB = 0;
  localparam int unsigned VEC_IDX_MSB = 2;
  localparam int unsigned VEC_ISV     = 4;
  localparam int unsigned VEC_VALID   = 7;

  function automatic logic [NUM_LINES-1:0] line_onehot(input logic [IDX_W-1:0] idx);
    line_onehot      = '0;
    line_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: line 0 wins over all others.
module irq_prio_enc
  import irq_ctrl_pkg::*;
(
  input  logic [NUM_LINES-1:0] req,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int unsigned i = NUM_LINES; i > 0; i--) begin
      if (req[i-1]) begin
        idx   = IDX_W'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// 8-line interrupt controller: synchronizes and latches requests, arbitrates
// by fixed priority and tracks the in-service line until EOI.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'hF0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_LINES-1:0] irq_src_i,
  input  logic [7:0]           io_addr_i,
  input  logic [7:0]           io_data_i,
  input  logic                 io_we_i,
  output logic [7:0]           io_data_o,
  output logic                 io_sel_o,
  output logic                 irq_o
);

  logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sync_q;
  logic [NUM_LINES-1:0] sync_lvl, prev_q, rise;
  logic [NUM_LINES-1:0] pend_q, mask_q, trig_q, isr_q;
  logic [NUM_LINES-1:0] pend_d, isr_d, cand_onehot;
  logic                 gen_q, irq_d;

  logic [7:0] ofs;
  logic       sel;
  logic       wr_pend, wr_mask, wr_ctrl, wr_cmd, wr_trig;
  logic       cmd_ack, cmd_eoi, ack_fire;
  logic [IDX_W-1:0] cand_idx;
  logic       cand_valid;
  logic [7:0] vec;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~prev_q;

  irq_prio_enc u_prio (
    .req   (pend_q & mask_q),
    .idx   (cand_idx),
    .valid (cand_valid)
  );

  assign cand_onehot = cand_valid ? line_onehot(cand_idx) : '0;

  always_comb begin
    ofs      = io_addr_i - BASE_ADDR;
    sel      = (ofs < NUM_REGS);
    wr_pend  = io_we_i && sel && (ofs == OFS_PEND);
    wr_mask  = io_we_i && sel && (ofs == OFS_MASK);
    wr_ctrl  = io_we_i && sel && (ofs == OFS_CTRL);
    wr_cmd   = io_we_i && sel && (ofs == OFS_CMD);
    wr_trig  = io_we_i && sel && (ofs == OFS_TRIG);
    // EOI takes precedence when both command bits are written together.
    cmd_eoi  = wr_cmd && io_data_i[CMD_EOI];
    cmd_ack  = wr_cmd && io_data_i[CMD_ACK] && !io_data_i[CMD_EOI];
    ack_fire = cmd_ack && cand_valid && (isr_q == '0);
  end

  always_comb begin
    pend_d = pend_q;
    for (int unsigned n = 0; n < NUM_LINES; n++) begin
      if (!trig_q[n]) begin
        pend_d[n] = sync_lvl[n];
      end else begin
        // A fresh edge beats both W1C and the ACK clear on the same bit.
        pend_d[n] = rise[n] |
                    (pend_q[n] & ~(wr_pend & io_data_i[n]) & ~(ack_fire & cand_onehot[n]));
      end
    end
  end

  always_comb begin
    isr_d = isr_q;
    if (cmd_eoi) begin
      isr_d = '0;
    end else if (ack_fire) begin
      isr_d = cand_onehot;
    end
  end

  // Uses the registered ISR, so irq_o stays low for a cycle after EOI.
  assign irq_d = gen_q && cand_valid && (isr_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      gen_q  <= 1'b0;
      isr_q  <= '0;
      trig_q <= '1;
      irq_o  <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src_i};
      end else begin
        sync_q <= irq_src_i;
      end
      prev_q <= sync_lvl;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      irq_o  <= irq_d;
      if (wr_mask) mask_q <= io_data_i;
      if (wr_ctrl) gen_q  <= io_data_i[CTRL_GEN];
      if (wr_trig) trig_q <= io_data_i;
    end
  end

  always_comb begin
    vec                          = '0;
    vec[VEC_VALID]               = cand_valid;
    vec[VEC_ISV]                 = (isr_q != '0);
    vec[VEC_IDX_MSB:VEC_IDX_LSB] = cand_idx;
  end

  always_comb begin
    io_sel_o  = sel;
    io_data_o = '0;
    if (sel) begin
      case (ofs)
        OFS_PEND: io_data_o = pend_q;
        OFS_MASK: io_data_o = mask_q;
        OFS_CTRL: io_data_o = {7'd0, gen_q};
        OFS_CMD:  io_data_o = vec;
        OFS_ISR:  io_data_o = isr_q;
        OFS_TRIG: io_data_o = trig_q;
        default:  io_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the register rules.
module tb_irq_controller;

  localparam logic [7:0]  BASE = 8'hF0;
  localparam int unsigned SS   = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] irq_src_i;
  logic [7:0] io_addr_i;
  logic [7:0] io_data_i;
  logic       io_we_i;
  logic [7:0] io_data_o;
  logic       io_sel_o;
  logic       irq_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state
  logic [7:0] m_pend, m_mask, m_trig, m_isr;
  logic       m_gen, m_irq;
  logic [7:0] m_hist [0:SS];   // m_hist[k] = source value sampled k+1 edges ago

  irq_controller #(.BASE_ADDR(BASE), .SYNC_STAGES(SS)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .irq_src_i (irq_src_i),
    .io_addr_i (io_addr_i),
    .io_data_i (io_data_i),
    .io_we_i   (io_we_i),
    .io_data_o (io_data_o),
    .io_sel_o  (io_sel_o),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic int unsigned bit_index(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) if (oh == (8'd1 << i)) return i;
    return 0;
  endfunction

  function automatic logic [7:0] m_vec();
    logic [7:0] pm, lo;
    pm = m_pend & m_mask;
    lo = pm & (~pm + 8'd1);
    return {(pm != 0), 2'b00, (m_isr != 0), 1'b0, 3'(bit_index(lo))};
  endfunction

  function automatic logic [7:0] exp_rd(input logic [7:0] addr);
    logic [7:0] off;
    off = addr - BASE;
    case (off)
      8'd0:    return m_pend;
      8'd1:    return m_mask;
      8'd2:    return {7'd0, m_gen};
      8'd3:    return m_vec();
      8'd4:    return m_isr;
      8'd5:    return m_trig;
      default: return 8'h00;
    endcase
  endfunction

  // One clock: compute the model's next state from the pre-edge inputs,
  // cross the edge, commit, then compare irq_o.
  task automatic cycle();
    logic [7:0] n_pend, n_mask, n_trig, n_isr, pm, lo, off, lvl, prv, d, src;
    logic       n_gen, n_irq, cv, wr, ackf, eoi;
    src = irq_src_i;
    d   = io_data_i;
    if (rst_i) begin
      n_pend = 8'h00; n_mask = 8'h00; n_trig = 8'hFF; n_isr = 8'h00;
      n_gen  = 1'b0;  n_irq  = 1'b0;
    end else begin
      lvl   = m_hist[SS-1];
      prv   = m_hist[SS];
      pm    = m_pend & m_mask;
      lo    = pm & (~pm + 8'd1);
      cv    = (pm != 0);
      off   = io_addr_i - BASE;
      wr    = io_we_i && (off < 8'd6);
      eoi   = wr && off == 8'd3 && d[1];
      ackf  = wr && off == 8'd3 && d[0] && !d[1] && cv && m_isr == 0;
      n_irq = m_gen && cv && m_isr == 0;
      n_isr = eoi ? 8'h00 : (ackf ? lo : m_isr);
      for (int n = 0; n < 8; n++) begin
        if (!m_trig[n]) n_pend[n] = lvl[n];
        else n_pend[n] = (lvl[n] && !prv[n]) ||
                         (m_pend[n] && !(wr && off == 8'd0 && d[n]) && !(ackf && lo[n]));
      end
      n_mask = (wr && off == 8'd1) ? d : m_mask;
      n_gen  = (wr && off == 8'd2) ? d[0] : m_gen;
      n_trig = (wr && off == 8'd5) ? d : m_trig;
    end
    @(posedge clk_i);
    m_pend = n_pend; m_mask = n_mask; m_trig = n_trig; m_isr = n_isr;
    m_gen  = n_gen;  m_irq  = n_irq;
    for (int k = SS; k > 0; k--) m_hist[k] = rst_i ? 8'h00 : m_hist[k-1];
    m_hist[0] = rst_i ? 8'h00 : src;
    #1;
    check("irq_o", {7'd0, irq_o}, {7'd0, m_irq});
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] data);
    io_addr_i = BASE + off;
    io_data_i = data;
    io_we_i   = 1'b1;
    cycle();
    io_we_i   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, output logic [7:0] v);
    io_we_i   = 1'b0;
    io_addr_i = addr;
    #1;
    v = io_data_o;
    check(tag, v, exp_rd(addr));
    check("sel", {7'd0, io_sel_o}, {7'd0, ((addr - BASE) < 8'd6)});
  endtask

  task automatic read_all();
    logic [7:0] v;
    for (int i = 0; i < 6; i++) rd("reg", BASE + 8'(i), v);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [7:0] v;
    rst_i = 1'b1; irq_src_i = 8'h00; io_addr_i = 8'h00; io_data_i = 8'h00; io_we_i = 1'b0;
    m_pend = 8'h00; m_mask = 8'h00; m_trig = 8'hFF; m_isr = 8'h00; m_gen = 1'b0; m_irq = 1'b0;
    for (int k = 0; k <= SS; k++) m_hist[k] = 8'h00;
    run(2);
    rst_i = 1'b0;
    read_all();
    rd("trig_rst", BASE + 8'd5, v); check("trig_rst_const", v, 8'hFF);

    // Single edge on line 3: three-edge latency, ACK, EOI
    wr(8'd1, 8'h08); wr(8'd2, 8'h01);
    irq_src_i = 8'h08; cycle(); irq_src_i = 8'h00;
    cycle(); check("lat_e1", {7'd0, irq_o}, 8'h00);
    cycle(); check("lat_e2", {7'd0, irq_o}, 8'h00);
    cycle(); check("lat_e3", {7'd0, irq_o}, 8'h01);
    rd("vec3", BASE + 8'd3, v); check("vec3_const", v, 8'h83);
    wr(8'd3, 8'h01);
    rd("isr3", BASE + 8'd4, v); check("isr3_const", v, 8'h08);
    rd("pend3", BASE + 8'd0, v); check("pend3_const", v, 8'h00);
    cycle(); check("ack_drop", {7'd0, irq_o}, 8'h00);
    wr(8'd3, 8'h02);
    rd("isr_eoi", BASE + 8'd4, v); check("isr_eoi_const", v, 8'h00);

    // Lines 5 and 2 together: priority and re-arm after EOI
    wr(8'd1, 8'hFF);
    irq_src_i = 8'h24; run(4); irq_src_i = 8'h00;
    check("dual_irq", {7'd0, irq_o}, 8'h01);
    rd("vec2", BASE + 8'd3, v); check("vec2_const", v, 8'h82);
    wr(8'd3, 8'h01);
    cycle(); check("svc2_low", {7'd0, irq_o}, 8'h00);
    rd("isr2", BASE + 8'd4, v); check("isr2_const", v, 8'h04);
    wr(8'd3, 8'h02); check("rearm_low", {7'd0, irq_o}, 8'h00);
    cycle(); check("rearm_high", {7'd0, irq_o}, 8'h01);
    rd("vec5", BASE + 8'd3, v); check("vec5_const", v, 8'h85);
    wr(8'd3, 8'h01); wr(8'd3, 8'h02);

    // Level-triggered line 1
    wr(8'd5, 8'hFD);
    irq_src_i = 8'h02; run(4);
    wr(8'd3, 8'h01); wr(8'd3, 8'h02); cycle();
    check("lvl_reassert", {7'd0, irq_o}, 8'h01);
    rd("lvl_pend", BASE + 8'd0, v); check("lvl_pend_const", v, 8'h02);
    irq_src_i = 8'h00; run(3);
    rd("lvl_drop", BASE + 8'd0, v); check("lvl_drop_const", v, 8'h00);
    cycle(); wr(8'd5, 8'hFF);

    // Masked line 4, unmask, then W1C racing a new edge
    wr(8'd1, 8'h00);
    irq_src_i = 8'h10; cycle(); irq_src_i = 8'h00; run(3);
    rd("mask_pend", BASE + 8'd0, v); check("mask_pend_const", v, 8'h10);
    check("masked_low", {7'd0, irq_o}, 8'h00);
    wr(8'd1, 8'h10); check("unmask_same", {7'd0, irq_o}, 8'h00);
    cycle(); check("unmask_next", {7'd0, irq_o}, 8'h01);
    irq_src_i = 8'h10; cycle(); irq_src_i = 8'h00; cycle();
    wr(8'd0, 8'h10);
    rd("w1c_race", BASE + 8'd0, v); check("w1c_race_const", v, 8'h10);
    wr(8'd0, 8'h10);
    rd("w1c_clr", BASE + 8'd0, v); check("w1c_clr_const", v, 8'h00);
    cycle();

    // Spurious ACK, ACK+EOI together, reset mid-service
    wr(8'd3, 8'h01);
    rd("spur_ack", BASE + 8'd4, v); check("spur_ack_const", v, 8'h00);
    wr(8'd1, 8'h01);
    irq_src_i = 8'h01; cycle(); irq_src_i = 8'h00; run(3);
    wr(8'd3, 8'h03);
    rd("ack_eoi", BASE + 8'd4, v); check("ack_eoi_const", v, 8'h00);
    wr(8'd3, 8'h01);
    rd("isr0", BASE + 8'd4, v); check("isr0_const", v, 8'h01);
    rst_i = 1'b1; cycle(); rst_i = 1'b0;
    check("rst_irq", {7'd0, irq_o}, 8'h00);
    read_all();
    rd("rst_isr", BASE + 8'd4, v); check("rst_isr_const", v, 8'h00);

    // Randomized traffic
    wr(8'd1, 8'hFF); wr(8'd2, 8'h01);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) irq_src_i = irq_src_i ^ 8'($urandom);
      rst_i = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) begin
        io_we_i   = 1'b1;
        io_addr_i = ($urandom_range(0, 7) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 6));
        io_data_i = 8'($urandom);
      end
      cycle();
      io_we_i = 1'b0; rst_i = 1'b0;
      rd("rand", ($urandom_range(0, 5) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 5)), v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- 8-line interrupt controller between peripheral interrupt sources and the core's single `irq_i` input.
- Latches and masks requests, then arbitrates them by fixed priority (line 0 highest).
- Drives a clean rising edge to the core once per serviced interrupt and tracks the in-service line until software issues EOI.
- Configured and serviced by the core through the 8-bit I/O port bus (IN/OUT instructions).

Parameters:
- BASE_ADDR, 8'hF0, I/O address of register offset 0; the block decodes BASE_ADDR..BASE_ADDR+5.
- SYNC_STAGES, 2, synchronizer flops per source line (minimum 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- irq_src_i  in  8  asynchronous interrupt request lines, bit n = line n.
- io_addr_i  in  8  core I/O address.
- io_data_i  in  8  core write data.
- io_we_i  in  1  core I/O write strobe, single cycle.
- io_data_o  out  8  read data, combinational from io_addr_i; 8'h00 when not selected.
- io_sel_o  out  1  high when io_addr_i is in BASE_ADDR..BASE_ADDR+5.
- irq_o  out  1  registered interrupt request to the core.

Interface: one clock (`clk_i`); reset `rst_i` is synchronous and active-high. All state changes happen on the rising edge of `clk_i`.

Behaviour:
- Register map (offset: access, function):
  - +0 PEND: R, W1C.
  - +1 MASK: RW, 1 = line enabled.
  - +2 CTRL: RW, bit0 = GEN (global enable), bits 7:1 read 0.
  - +3 CMD/VEC:
    - Write: bit0 = ACK, bit1 = EOI.
    - Read: {valid, 2'b0, isv, 1'b0, idx[2:0]}, where valid = candidate exists, isv = a line is in service, idx = candidate index.
  - +4 ISR: R, one-hot in-service line.
  - +5 TRIG: RW, 1 = edge-triggered, 0 = level-triggered.
- Reset values: PEND = 0, MASK = 0, CTRL = 0, ISR = 0, TRIG = 8'hFF, all synchronizer and edge flops = 0, irq_o = 0.
- Synchronization: each source passes SYNC_STAGES flops. An edge line sets PEND[n] when the synchronized value is 1 and its previous value was 0.
- Level lines: PEND[n] = synchronized level every cycle; W1C has no effect.
- Latency (SYNC_STAGES = 2): source high before edge t → PEND[n] set at edge t+2 → irq_o high at edge t+3.
- Candidate: lowest index n with PEND[n] & MASK[n].
- irq_o next value = GEN & (candidate exists) & (ISR == 0). No nesting.
- ACK write, all conditions true (candidate exists, ISR == 0): ISR gets the candidate's one-hot bit; an edge line's PEND bit clears in the same cycle; irq_o falls next edge.
- ACK write, otherwise: ignored.
- EOI write: ISR clears. If ISR == 0, no effect.
- Re-arm: irq_o stays low at least one cycle after EOI before it can re-rise, so the core's edge detector always sees a fresh edge.
- ACK and EOI both set in one write: EOI is applied, ACK is ignored.
- Same-cycle conflicts:
  - New source edge and W1C on the same bit: set wins.
  - MASK write and candidate change: the new MASK is used from the next cycle.
- Masked lines still latch into PEND; unmasking a pending line raises irq_o next cycle if the other conditions hold.
- Clearing GEN drops irq_o next edge; PEND and ISR are preserved.
- Writes to offsets +4 and to unmapped addresses are ignored. Reads have no side effects.
- rst_i asserted mid-service: returns every register to its reset value on that edge, dropping any in-service line.

Decomposition:
- Package irq_ctrl_pkg holds:
  - register offset localparams (OFS_PEND..OFS_TRIG);
  - CMD bit positions (CMD_ACK = 0, CMD_EOI = 1);
  - VEC field positions;
  - NUM_LINES = 8.
- Sub-module irq_prio_enc: combinational 8-to-3 lowest-index-first priority encoder with a valid output.
- Synchronizer, edge detect and register file stay in the top module.

Test Plan:
- Reset, then read all offsets → PEND = 00, MASK = 00, CTRL = 00, ISR = 00, TRIG = FF, irq_o = 0.
- MASK = 8'h08, GEN = 1, pulse irq_src_i[3] for 1 cycle → irq_o high exactly 3 edges later; VEC reads 8'h83. Write ACK → irq_o low next edge, ISR = 08, PEND = 00. Write EOI → ISR = 00.
- MASK = FF, lines 5 and 2 rise in the same cycle:
  - VEC idx = 2; ACK → ISR = 04, irq_o stays low.
  - EOI → irq_o low for ≥1 cycle, then rises; VEC idx = 5.
- TRIG[1] = 0, hold irq_src_i[1] high, ACK, EOI → PEND[1] still 1, irq_o re-asserts; drop source → PEND[1] = 0 after sync latency.
- Line 4 edge while MASK[4] = 0 → PEND = 10, irq_o stays 0; write MASK = 10 → irq_o high next edge. Write PEND W1C 10 in the same cycle as a new edge on line 4 → PEND[4] remains 1.
- Spurious commands: ACK with no candidate → ISR unchanged; assert rst_i while ISR = 01 → all registers at reset values and irq_o = 0 on the next edge.
